// File: rtl/seq_ram_if.sv
// Strobe/response bundle between the button sequencer (master) and seq_ram (slave).
// The names follow the sequencer's existing signal names.
interface seq_ram_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] WriteAddr;
    logic [ADDR_W-1:0] ReadAddr;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic              rvalid;
    logic              wack;
    logic              ready;
    logic [ADDR_W:0]   used;
    logic              err;

    modport master (
        output write, read, WriteAddr, ReadAddr, WriteData,
        input  ReadData, rvalid, wack, ready, used, err
    );

    modport slave (
        input  write, read, WriteAddr, ReadAddr, WriteData,
        output ReadData, rvalid, wack, ready, used, err
    );
endinterface

// File: rtl/seq_ram.sv
// Step-pattern store for the button sequencer. After reset it runs a fill sweep, then
// serves one read and one write per cycle, and counts the distinct entries written.
module seq_ram #(
    parameter int                ADDR_W = 2,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic     clk,
    input  logic     reset,  // active-low, asynchronous
    seq_ram_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, IDLE} state_e;

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] ptr_q,     ptr_d;
    logic [DEPTH-1:0]  written_q, written_d;
    logic [ADDR_W:0]   used_q,    used_d;
    logic              err_q,     err_d;
    logic              rvalid_q,  rvalid_d;
    logic              wack_q,    wack_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        ptr_d     = ptr_q;
        written_d = written_q;
        used_d    = used_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        wack_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = bus.WriteAddr;
        mem_wdata = bus.WriteData;

        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = FILL;
                ptr_d     = ptr_q + ADDR_W'(1);
                written_d = '0;
                used_d    = '0;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
                // Strobes are dropped here; only the sticky flag records them.
                if (bus.read || bus.write) begin
                    err_d = 1'b1;
                end
            end

            IDLE: begin
                if (bus.write) begin
                    mem_we = 1'b1;
                    wack_d = 1'b1;
                    if (!written_q[bus.WriteAddr] && used_q != (ADDR_W + 1)'(DEPTH)) begin
                        written_d[bus.WriteAddr] = 1'b1;
                        used_d                   = used_q + (ADDR_W + 1)'(1);
                    end
                end
                if (bus.read) begin
                    rvalid_d = 1'b1;
                    // Write-first: a same-address read sees the data being written this cycle.
                    if (bus.write && bus.WriteAddr == bus.ReadAddr) begin
                        rdata_d = bus.WriteData;
                    end else begin
                        rdata_d = mem[bus.ReadAddr];
                    end
                end
            end

            default: state_d = INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= INIT;
            ptr_q     <= '0;
            written_q <= '0;
            used_q    <= '0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            wack_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            written_q <= written_d;
            used_q    <= used_d;
            err_q     <= err_d;
            rvalid_q  <= rvalid_d;
            wack_q    <= wack_d;
            rdata_q   <= rdata_d;
        end
    end

    // NOTE: the array has no reset so it maps onto plain storage; the fill sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.ReadData = rdata_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.wack     = wack_q;
    assign bus.ready    = (state_q == IDLE);
    assign bus.used     = used_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_seq_ram.sv
// Directed bench for seq_ram: fill sweep, write/readback, collisions, illegal strobes,
// reset mid-operation and held strobes, with hand-computed expectations.
module tb_seq_ram;
    localparam int          ADDR_W = 2;
    localparam int          DATA_W = 8;
    localparam logic [7:0]  FILL   = 8'hA5;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miscompare;

    seq_ram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    seq_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .FILL  (FILL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                         input logic r, input logic [1:0] ra);
        bus.write     = w;
        bus.WriteAddr = wa;
        bus.WriteData = wd;
        bus.read      = r;
        bus.ReadAddr  = ra;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    endtask

    // Sweep takes 4 edges after release: ready low after edges 1..3, high after edge 4.
    task automatic expect_sweep(input string tag);
        check({tag, "_ready_pre"}, 32'(bus.ready), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("%s_ready_e%0d", tag, i), 32'(bus.ready), (i == 4) ? 32'd1 : 32'd0);
        end
    endtask

    logic [7:0] exp_rd [4];
    logic [7:0] wr_data [4];

    initial begin
        n_vec        = 0;
        n_miscompare = 0;
        idle();
        reset = 1'b1;
        #2 reset = 1'b0;

        // Reset values.
        tick();
        tick();
        check("rst_rdata",  32'(bus.ReadData), 32'h0);
        check("rst_rvalid", 32'(bus.rvalid),   32'd0);
        check("rst_wack",   32'(bus.wack),     32'd0);
        check("rst_ready",  32'(bus.ready),    32'd0);
        check("rst_used",   32'(bus.used),     32'd0);
        check("rst_err",    32'(bus.err),      32'd0);

        // Fill sweep, then back-to-back reads of the FILL value.
        reset = 1'b1;
        expect_sweep("fill");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1, 2'(i));
            tick();
            check($sformatf("fill_rd%0d", i),     32'(bus.ReadData), 32'(FILL));
            check($sformatf("fill_rvalid%0d", i), 32'(bus.rvalid),   32'd1);
        end
        idle();
        tick();
        check("fill_rvalid_drop", 32'(bus.rvalid), 32'd0);
        check("fill_used",        32'(bus.used),   32'd0);
        check("fill_err",         32'(bus.err),    32'd0);

        // Writes to every entry: used counts 1..4.
        wr_data = '{8'h03, 8'h01, 8'h02, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), wr_data[i], 1'b0, 2'd0);
            tick();
            check($sformatf("wr_wack%0d", i), 32'(bus.wack), 32'd1);
            check($sformatf("wr_used%0d", i), 32'(bus.used), 32'(i + 1));
        end
        // Rewrite of an already-written entry leaves used at 4.
        drive(1'b1, 2'd1, 8'h02, 1'b0, 2'd0);
        tick();
        check("rewr_wack", 32'(bus.wack), 32'd1);
        check("rewr_used", 32'(bus.used), 32'd4);
        idle();
        tick();
        check("wack_drop", 32'(bus.wack), 32'd0);

        exp_rd = '{8'h03, 8'h02, 8'h02, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1, 2'(i));
            tick();
            check($sformatf("rb_rd%0d", i), 32'(bus.ReadData), 32'(exp_rd[i]));
        end

        // Same-address collision is write-first.
        drive(1'b1, 2'd2, 8'h5C, 1'b1, 2'd2);
        tick();
        check("col_rd",     32'(bus.ReadData), 32'h5C);
        check("col_rvalid", 32'(bus.rvalid),   32'd1);
        check("col_wack",   32'(bus.wack),     32'd1);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
        tick();
        check("col_rd_next", 32'(bus.ReadData), 32'h5C);
        check("col_wack_next", 32'(bus.wack),   32'd0);

        // Different addresses in one cycle complete independently.
        drive(1'b1, 2'd0, 8'h77, 1'b1, 2'd3);
        tick();
        check("diff_rd",   32'(bus.ReadData), 32'h00);
        check("diff_wack", 32'(bus.wack),     32'd1);
        check("diff_used", 32'(bus.used),     32'd4);

        // Held read strobe: three independent reads.
        exp_rd = '{8'h77, 8'h02, 8'h5C, 8'h00};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1, 2'(i));
            tick();
            check($sformatf("hold_rd%0d", i),     32'(bus.ReadData), 32'(exp_rd[i]));
            check($sformatf("hold_rvalid%0d", i), 32'(bus.rvalid),   32'd1);
        end
        idle();

        // Reset pulsed during a read clears outputs at once and restarts the sweep.
        drive(1'b1, 2'd0, 8'h11, 1'b1, 2'd3);
        tick();
        check("mid_rvalid_pre", 32'(bus.rvalid), 32'd1);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
        reset = 1'b0;
        #1;
        check("mid_rvalid", 32'(bus.rvalid),   32'd0);
        check("mid_used",   32'(bus.used),     32'd0);
        check("mid_ready",  32'(bus.ready),    32'd0);
        check("mid_rdata",  32'(bus.ReadData), 32'h0);
        tick();
        idle();
        reset = 1'b1;
        expect_sweep("mid");
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
        tick();
        check("mid_rd0", 32'(bus.ReadData), 32'(FILL));
        check("mid_err", 32'(bus.err),      32'd0);
        idle();

        // Illegal write during the second sweep cycle: dropped, err sticks.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        drive(1'b1, 2'd1, 8'hFF, 1'b0, 2'd0);
        tick();
        check("ill_err",  32'(bus.err),  32'd1);
        check("ill_wack", 32'(bus.wack), 32'd0);
        idle();
        tick();
        tick();
        check("ill_ready", 32'(bus.ready), 32'd1);
        check("ill_used",  32'(bus.used),  32'd0);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
        tick();
        check("ill_rd1",      32'(bus.ReadData), 32'(FILL));
        check("ill_err_hold", 32'(bus.err),      32'd1);
        idle();
        tick();
        check("ill_err_stay", 32'(bus.err), 32'd1);
        reset = 1'b0;
        #1;
        check("ill_err_clr", 32'(bus.err), 32'd0);
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end
endmodule
